// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe: registered RV32 decode-control stage between fetch and execute.
// Decodes the instruction word into control flags and a one-hot class vector,
// registers them behind a valid/ready handshake with flush, stalls M-extension
// instructions while the multi-cycle M unit is occupied, and keeps a saturating
// count of accepted illegal instructions.
//
// Ports:
//   clk, rst_n           clock (rising edge), asynchronous active-low reset
//   flush                kill the output register, block acceptance this cycle
//   in_valid/in_ready    input handshake (in_ready is combinational)
//   in_instr[31:0]       opcode=[6:0], func3=[14:12], func7=[31:25]
//   out_valid/out_ready  output handshake
//   ex_alu_src, s_type_inst, wb_load, wb_reg_file, m_type_inst, invalid_inst
//                        registered control flags
//   decoded_instruction  one-hot class {R, I, S, LOAD, LUI, B, JAL, AUIPC, JALR}
//   m_busy               M unit occupied
//   illegal_count        saturating count of accepted invalid instructions
module decode_ctrl_pipe #(
  parameter int unsigned M_ENABLE   = 1,
  parameter int unsigned MUL_CYCLES = 3,
  parameter int unsigned DIV_CYCLES = 33,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ex_alu_src,
  output logic             s_type_inst,
  output logic             wb_load,
  output logic             wb_reg_file,
  output logic             m_type_inst,
  output logic             invalid_inst,
  output logic [8:0]       decoded_instruction,
  output logic             m_busy,
  output logic [CNT_W-1:0] illegal_count
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_I     = 7'b0010011,
    OP_S     = 7'b0100011,
    OP_LOAD  = 7'b0000011,
    OP_LUI   = 7'b0110111,
    OP_B     = 7'b1100011,
    OP_JAL   = 7'b1101111,
    OP_AUIPC = 7'b0010111,
    OP_JALR  = 7'b1100111
  } opcode_e;

  typedef enum logic [6:0] {
    F7_ADD = 7'b0000000,
    F7_SUB = 7'b0100000,
    F7_M   = 7'b0000001
  } func7_e;

  logic [6:0] w_op;
  logic [6:0] w_f7;
  logic       w_is_r, w_is_i, w_is_s, w_is_load, w_is_lui;
  logic       w_is_b, w_is_jal, w_is_auipc, w_is_jalr;
  logic [8:0] w_cls;
  logic       w_alu_src;
  logic       w_wb;
  logic       w_is_m;
  logic       w_invalid;
  logic       w_m_busy;
  logic       w_accept;
  logic       w_unused;

  logic             r_valid;
  logic             r_alu_src;
  logic             r_store;
  logic             r_load;
  logic             r_wb;
  logic             r_m;
  logic             r_invalid;
  logic [8:0]       r_cls;
  logic [7:0]       r_mcnt;
  logic [CNT_W-1:0] r_ill;

  assign w_op = in_instr[6:0];
  assign w_f7 = in_instr[31:25];

  // Only opcode, func3[2] and func7 take part in decode.
  assign w_unused = &{1'b0, in_instr[24:15], in_instr[13:7]};

  always_comb begin
    w_is_r     = (w_op == OP_R);
    w_is_i     = (w_op == OP_I);
    w_is_s     = (w_op == OP_S);
    w_is_load  = (w_op == OP_LOAD);
    w_is_lui   = (w_op == OP_LUI);
    w_is_b     = (w_op == OP_B);
    w_is_jal   = (w_op == OP_JAL);
    w_is_auipc = (w_op == OP_AUIPC);
    w_is_jalr  = (w_op == OP_JALR);
    w_cls      = {w_is_r, w_is_i, w_is_s, w_is_load, w_is_lui,
                  w_is_b, w_is_jal, w_is_auipc, w_is_jalr};
    w_alu_src  = w_is_i | w_is_load | w_is_s | w_is_lui | w_is_auipc | w_is_jalr;
    w_wb       = w_is_r | w_is_i | w_is_load | w_is_lui | w_is_auipc |
                 w_is_jalr | w_is_jal;
    w_is_m     = w_is_r & (w_f7 == F7_M) & (M_ENABLE != 0);
    w_invalid  = !((w_is_r & ((w_f7 == F7_ADD) | (w_f7 == F7_SUB))) |
                   w_is_m | w_alu_src | w_is_b | w_is_jal);
  end

  assign w_m_busy = (r_mcnt != '0);

  // An M instruction stalls while the unit is busy, including its last cycle
  // (count 1), so a load never coincides with a decrement.
  assign in_ready = !flush & (!r_valid | out_ready) & !(w_is_m & w_m_busy);
  assign w_accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= 1'b0;
      r_alu_src <= 1'b0;
      r_store   <= 1'b0;
      r_load    <= 1'b0;
      r_wb      <= 1'b0;
      r_m       <= 1'b0;
      r_invalid <= 1'b0;
      r_cls     <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_alu_src <= w_alu_src;
      r_store   <= w_is_s;
      r_load    <= w_is_load;
      r_wb      <= w_wb;
      r_m       <= w_is_m;
      r_invalid <= w_invalid;
      r_cls     <= w_cls;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcnt <= '0;
    end else if (w_accept & w_is_m) begin
      r_mcnt <= in_instr[14] ? 8'(DIV_CYCLES) : 8'(MUL_CYCLES);
    end else if (w_m_busy) begin
      r_mcnt <= r_mcnt - 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill <= '0;
    end else if (w_accept & w_invalid & ~&r_ill) begin
      r_ill <= r_ill + CNT_W'(1);
    end
  end

  assign out_valid           = r_valid;
  assign ex_alu_src          = r_alu_src;
  assign s_type_inst         = r_store;
  assign wb_load             = r_load;
  assign wb_reg_file         = r_wb;
  assign m_type_inst         = r_m;
  assign invalid_inst        = r_invalid;
  assign decoded_instruction = r_cls;
  assign m_busy              = w_m_busy;
  assign illegal_count       = r_ill;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
module tb_decode_ctrl_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Default-parameter instance
  logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic [31:0] a_in_instr = '0;
  logic        a_in_ready, a_out_valid, a_alu, a_st, a_ld, a_wb, a_m, a_inv, a_m_busy;
  logic [8:0]  a_cls;
  logic [15:0] a_ill;

  // M_ENABLE=0, CNT_W=2 instance
  logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b1;
  logic [31:0] b_in_instr = '0;
  logic        b_in_ready, b_out_valid, b_alu, b_st, b_ld, b_wb, b_m, b_inv, b_m_busy;
  logic [8:0]  b_cls;
  logic [1:0]  b_ill;

  decode_ctrl_pipe dut_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .in_instr(a_in_instr), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .ex_alu_src(a_alu), .s_type_inst(a_st),
    .wb_load(a_ld), .wb_reg_file(a_wb), .m_type_inst(a_m), .invalid_inst(a_inv),
    .decoded_instruction(a_cls), .m_busy(a_m_busy), .illegal_count(a_ill));

  decode_ctrl_pipe #(.M_ENABLE(0), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .in_instr(b_in_instr), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .ex_alu_src(b_alu), .s_type_inst(b_st),
    .wb_load(b_ld), .wb_reg_file(b_wb), .m_type_inst(b_m), .invalid_inst(b_inv),
    .decoded_instruction(b_cls), .m_busy(b_m_busy), .illegal_count(b_ill));

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;
  localparam logic [31:0] I_LW  = 32'h0000A183;
  localparam logic [31:0] I_SW  = 32'h0030A023;
  localparam logic [31:0] I_BAD = 32'h0000007F;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [8:0]  cls;
    logic        alu, st, ld, wb, m, inv;
  } vec_t;

  vec_t vecs[13];
  int checks = 0;
  int failures = 0;
  int exp_ill = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (a_m_busy && n < 100) begin
      tick();
      n++;
    end
    chk("m_idle_wait", {31'd0, a_m_busy}, 32'd0);
  endtask

  function automatic vec_t mk(string nm, logic [31:0] ins, logic [8:0] c,
                              logic al, logic s, logic l, logic w, logic m, logic iv);
    vec_t v;
    v.name = nm; v.instr = ins; v.cls = c;
    v.alu = al; v.st = s; v.ld = l; v.wb = w; v.m = m; v.inv = iv;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    //                 name     instr          class         alu st ld wb m inv
    vecs[0]  = mk("add",   I_ADD,        9'b100000000, 0, 0, 0, 1, 0, 0);
    vecs[1]  = mk("sub",   32'h402081B3, 9'b100000000, 0, 0, 0, 1, 0, 0);
    vecs[2]  = mk("rbad",  32'h202081B3, 9'b100000000, 0, 0, 0, 1, 0, 1);
    vecs[3]  = mk("addi",  32'h00108093, 9'b010000000, 1, 0, 0, 1, 0, 0);
    vecs[4]  = mk("lw",    I_LW,         9'b000100000, 1, 0, 1, 1, 0, 0);
    vecs[5]  = mk("sw",    I_SW,         9'b001000000, 1, 1, 0, 0, 0, 0);
    vecs[6]  = mk("lui",   32'h000010B7, 9'b000010000, 1, 0, 0, 1, 0, 0);
    vecs[7]  = mk("beq",   32'h00208063, 9'b000001000, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk("jal",   32'h0000006F, 9'b000000100, 0, 0, 0, 1, 0, 0);
    vecs[9]  = mk("auipc", 32'h00000097, 9'b000000010, 1, 0, 0, 1, 0, 0);
    vecs[10] = mk("jalr",  32'h000080E7, 9'b000000001, 1, 0, 0, 1, 0, 0);
    vecs[11] = mk("bad",   I_BAD,        9'b000000000, 0, 0, 0, 0, 0, 1);
    vecs[12] = mk("mul",   I_MUL,        9'b100000000, 0, 0, 0, 1, 1, 0);

    // Reset state
    tick(); tick();
    chk("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("rst_cls", {23'd0, a_cls}, 32'd0);
    chk("rst_m_busy", {31'd0, a_m_busy}, 32'd0);
    chk("rst_ill", {16'd0, a_ill}, 32'd0);
    chk("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    rst_n = 1'b1;

    // Decode table, back-to-back with out_ready=1
    a_in_valid = 1'b1;
    for (int unsigned i = 0; i < 13; i++) begin
      a_in_instr = vecs[i].instr;
      #1 chk({vecs[i].name, "_in_ready"}, {31'd0, a_in_ready}, 32'd1);
      tick();
      if (vecs[i].inv) exp_ill++;
      chk({vecs[i].name, "_out_valid"}, {31'd0, a_out_valid}, 32'd1);
      chk({vecs[i].name, "_cls"}, {23'd0, a_cls}, {23'd0, vecs[i].cls});
      chk({vecs[i].name, "_flags"}, {26'd0, a_alu, a_st, a_ld, a_wb, a_m, a_inv},
          {26'd0, vecs[i].alu, vecs[i].st, vecs[i].ld, vecs[i].wb, vecs[i].m, vecs[i].inv});
      chk({vecs[i].name, "_ill"}, {16'd0, a_ill}, exp_ill);
    end

    // Drain: out_valid drops, payload kept
    a_in_valid = 1'b0;
    tick();
    chk("drain_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("drain_payload", {22'd0, a_cls, a_m}, {22'd0, 9'b100000000, 1'b1});
    wait_idle();

    // MUL then DIV with an interleaved ADD during the stall
    a_in_instr = I_MUL; a_in_valid = 1'b1;
    tick();
    chk("mul_m_type", {31'd0, a_m}, 32'd1);
    chk("mul_busy", {31'd0, a_m_busy}, 32'd1);
    a_in_instr = I_DIV;
    #1 chk("div_stall_c1", {31'd0, a_in_ready}, 32'd0);
    tick();
    a_in_instr = I_ADD;
    #1 chk("add_in_stall_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    chk("add_in_stall_out", {22'd0, a_cls, a_m}, {22'd0, 9'b100000000, 1'b0});
    a_in_instr = I_DIV;
    #1 chk("div_stall_c3", {31'd0, a_in_ready}, 32'd0);
    chk("div_stall_c3_busy", {31'd0, a_m_busy}, 32'd1);
    tick();
    chk("div_ready_c4", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 1'b0;
    chk("div_accepted", {30'd0, a_out_valid, a_m}, 32'd3);
    begin
      int n = 0;
      while (a_m_busy && n < 40) begin
        n++;
        tick();
      end
      chk("div_busy_cycles", n, 32'd33);
    end

    // Backpressure
    a_in_instr = I_LW; a_in_valid = 1'b1; a_out_ready = 1'b1;
    tick();
    a_in_instr = I_SW; a_out_ready = 1'b0;
    #1 chk("bp_in_ready", {31'd0, a_in_ready}, 32'd0);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      chk("bp_held", {28'd0, a_out_valid, a_ld, a_alu, a_st}, {28'd0, 4'b1110});
      chk("bp_in_ready_hold", {31'd0, a_in_ready}, 32'd0);
    end
    a_out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 1'b0;
    chk("bp_sw_out", {29'd0, a_out_valid, a_st, a_wb}, {29'd0, 3'b110});

    // Flush with an M op outstanding and an illegal instruction offered
    a_in_instr = I_MUL; a_in_valid = 1'b1;
    tick();
    a_in_instr = I_BAD; a_flush = 1'b1;
    #1 chk("flush_in_ready", {31'd0, a_in_ready}, 32'd0);
    tick();
    chk("flush_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("flush_m_busy", {31'd0, a_m_busy}, 32'd1);
    chk("flush_ill", {16'd0, a_ill}, exp_ill);
    a_flush = 1'b0; a_in_instr = I_ADD;
    #1 chk("post_flush_ready", {31'd0, a_in_ready}, 32'd1);
    tick();
    a_in_valid = 1'b0;
    chk("post_flush_accept", {22'd0, a_out_valid, a_cls}, {22'd0, 1'b1, 9'b100000000});
    wait_idle();

    // Saturating counter on the CNT_W=2 instance
    b_in_instr = I_BAD; b_in_valid = 1'b1;
    for (int unsigned i = 1; i <= 5; i++) begin
      tick();
      chk("sat_ill", {30'd0, b_ill}, (i > 3) ? 32'd3 : i);
    end
    b_in_valid = 1'b0;

    // Asynchronous reset in the middle of a DIV stall
    a_in_instr = I_MUL; a_in_valid = 1'b1;
    tick();
    a_in_instr = I_DIV;
    tick();
    chk("pre_rst_busy", {31'd0, a_m_busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_m_busy", {31'd0, a_m_busy}, 32'd0);
    chk("arst_ill", {16'd0, a_ill}, 32'd0);
    chk("arst_out_valid", {31'd0, a_out_valid}, 32'd0);
    chk("arst_flags", {20'd0, a_cls, a_alu, a_wb, a_m}, 32'd0);
    chk("arst_b_ill", {30'd0, b_ill}, 32'd0);
    chk("arst_in_ready", {31'd0, a_in_ready}, 32'd1);
    a_in_valid = 1'b0;
    tick();
    rst_n = 1'b1;

    // M_ENABLE=0: MUL decodes as invalid and never occupies the M unit
    b_in_instr = I_MUL; b_in_valid = 1'b1;
    tick();
    b_in_valid = 1'b0;
    chk("m0_flags", {28'd0, b_out_valid, b_m, b_inv, b_wb}, {28'd0, 4'b1011});
    chk("m0_cls", {23'd0, b_cls}, {23'd0, 9'b100000000});
    chk("m0_m_busy", {31'd0, b_m_busy}, 32'd0);
    chk("m0_ill", {30'd0, b_ill}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
